// File: rtl/shift_reg8_pkg.sv
// Shared constants and helpers for the serial-in / parallel-out shift register.
// The default register width lives here so the RTL and its bench agree on it.
package shift_reg8_pkg;

  localparam int SR_WIDTH = 8;

  // One shift step: the new bit enters the LSB and the old MSB is discarded.
  function automatic logic [SR_WIDTH-1:0] shift_in_lsb(
    input logic [SR_WIDTH-1:0] cur,
    input logic                bit_in
  );
    return {cur[SR_WIDTH-2:0], bit_in};
  endfunction

endpackage

// File: rtl/shift_reg8_if.sv
// Bundles the serial input and parallel output of shift_reg8 for a producer and a consumer.
// The master drives the serial stream; the slave side owns the parallel word.
interface shift_reg8_if
  import shift_reg8_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
);

  logic             in_data;
  logic [WIDTH-1:0] data;

  modport master (
    output in_data,
    input  data
  );

  modport slave (
    input  in_data,
    output data
  );

endinterface

// File: rtl/shift_reg8.sv
// 8-bit serial-in / parallel-out shift register; data[0] holds the newest bit.
// Output comes straight from the flops; synchronous active-high reset wins over shifting.
module shift_reg8
  import shift_reg8_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             in_data,
  input  logic             reset,
  input  logic             Clk,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (reset) begin
      data_d = '0;
    end else begin
      data_d = {data_q[WIDTH-2:0], in_data};
    end
  end

  // No power-up value: the word stays unknown until the first reset edge.
  always_ff @(posedge Clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: tb/tb_shift_reg8.sv
// Directed bench for shift_reg8: stimulus on the falling edge, checks 1 ns after the rising edge.
module tb_shift_reg8;
  import shift_reg8_pkg::*;

  logic Clk;
  logic reset;
  int   total;
  int   bad;

  shift_reg8_if #(.WIDTH(SR_WIDTH)) sr_if ();

  shift_reg8 #(.WIDTH(SR_WIDTH)) dut (
    .in_data (sr_if.in_data),
    .reset   (reset),
    .Clk     (Clk),
    .data    (sr_if.data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] exp);
    total++;
    assert (sr_if.data === exp)
      else begin
        bad++;
        $error("FAIL %s: data=%h expected=%h", tag, sr_if.data, exp);
      end
  endtask

  // Drive one edge worth of inputs, then check the word that edge produced.
  task automatic step(input logic rst, input logic din, input string tag, input logic [7:0] exp);
    @(negedge Clk);
    reset         = rst;
    sr_if.in_data = din;
    @(posedge Clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    sr_if.in_data = 1'b0;

    // Reset dominates a high input
    step(1'b1, 1'b1, "rst_dominates", 8'h00);

    // Shift 1,0,1,1
    step(1'b0, 1'b1, "seq_1", 8'h01);
    step(1'b0, 1'b0, "seq_10", 8'h02);
    step(1'b0, 1'b1, "seq_101", 8'h05);
    step(1'b0, 1'b1, "seq_1011", 8'h0B);

    // Mid-stream reset, then resume from zero
    step(1'b1, 1'b0, "mid_rst", 8'h00);
    step(1'b0, 1'b1, "resume_1", 8'h01);

    // Fill with ones, then drop the MSB
    step(1'b1, 1'b1, "rst_before_fill", 8'h00);
    step(1'b0, 1'b1, "fill_1", 8'h01);
    step(1'b0, 1'b1, "fill_2", 8'h03);
    step(1'b0, 1'b1, "fill_3", 8'h07);
    step(1'b0, 1'b1, "fill_4", 8'h0F);
    step(1'b0, 1'b1, "fill_5", 8'h1F);
    step(1'b0, 1'b1, "fill_6", 8'h3F);
    step(1'b0, 1'b1, "fill_7", 8'h7F);
    step(1'b0, 1'b1, "fill_8", 8'hFF);
    step(1'b0, 1'b0, "fill_drop_msb", 8'hFE);

    // Walk a single one up to the MSB, then shift it out
    step(1'b1, 1'b0, "rst_before_walk", 8'h00);
    step(1'b0, 1'b1, "walk_0", 8'h01);
    step(1'b0, 1'b0, "walk_1", 8'h02);
    step(1'b0, 1'b0, "walk_2", 8'h04);
    step(1'b0, 1'b0, "walk_3", 8'h08);
    step(1'b0, 1'b0, "walk_4", 8'h10);
    step(1'b0, 1'b0, "walk_5", 8'h20);
    step(1'b0, 1'b0, "walk_6", 8'h40);
    step(1'b0, 1'b0, "walk_7", 8'h80);
    step(1'b0, 1'b0, "msb_out_no_wrap", 8'h00);

    // Toggle the input between edges; only the edge-sampled value counts
    step(1'b0, 1'b1, "pre_toggle", 8'h01);
    @(negedge Clk);
    reset         = 1'b0;
    sr_if.in_data = 1'b1;
    #1 sr_if.in_data = 1'b0;
    #1 sr_if.in_data = 1'b1;
    #1 check("hold_between_edges", 8'h01);
    sr_if.in_data = 1'b0;
    @(posedge Clk);
    #1;
    check("toggle_edge_sample", 8'h02);
    // A late glitch after the edge must not disturb the word
    sr_if.in_data = 1'b1;
    #2 check("glitch_after_edge", 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, elapsed=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
